apb_slv_mem: RTL
================

APB_SLV_MEM -- requirements
Module: apb_slv_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, PADDR width in bits (byte address).
REQ-002 Parameter DATA_WIDTH, default 32, PWDATA/PRDATA width; legal values 8, 16, 32.
REQ-003 Parameter MEM_DEPTH, default 16, number of DATA_WIDTH-bit words in storage.
REQ-004 Parameter WAIT_CYCLES, default 2, PREADY-low cycles inserted in every access phase (0..15).
REQ-005 One clock; reset is asynchronous and active-low; ports named PCLK and PRESETn.
REQ-006 PCLK  input  1  clock; all state updates on rising edge.
REQ-007 PRESETn  input  1  asynchronous active-low reset.
REQ-008 PSELx  input  1  slave select.
REQ-009 PENABLE  input  1  access-phase qualifier.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  ADDR_WIDTH  byte address.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PSTRB  input  DATA_WIDTH/8  write byte-lane enables; bit n gates PWDATA[8n+7:8n].
REQ-014 PRDATA  output  DATA_WIDTH  read data.
REQ-015 PREADY  output  1  transfer-complete / wait-state control.
REQ-016 PSLVERR  output  1  transfer error.

Function
REQ-017 Slave SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-018 IDLE -> ACCESS when PSELx=1 and PENABLE=0 (setup phase); on that edge SHALL capture PADDR, PWRITE, PWDATA, PSTRB and load wait counter with WAIT_CYCLES.
REQ-019 In ACCESS with counter != 0: PREADY=0, counter decrements by 1 per cycle.
REQ-020 In ACCESS with counter == 0: PREADY=1 combinationally from state/counter only (no input-to-PREADY path).
REQ-021 Transfer completes on the edge where state=ACCESS, counter=0, PSELx=1, PENABLE=1; FSM returns to IDLE.
REQ-022 Back-to-back: a setup phase presented in the cycle after completion SHALL be accepted per REQ-018 with no extra idle cycle.
REQ-023 PSELx=0 while in ACCESS SHALL abort to IDLE: no memory write, PREADY and PSLVERR remain 0.
REQ-024 PENABLE=1 while in IDLE (no setup) SHALL be ignored: state stays IDLE, PREADY=0.
REQ-025 Word index = captured PADDR >> log2(DATA_WIDTH/8).
REQ-026 Error condition: word index >= MEM_DEPTH, or captured PADDR not aligned to DATA_WIDTH/8 bytes.
REQ-027 PSLVERR SHALL equal the error condition while PREADY=1, and 0 at all other times.
REQ-028 Write on completing edge, no error: for each PSTRB bit set, update that byte lane; unset lanes unchanged.
REQ-029 Write with PSTRB all zero: memory unchanged, PSLVERR=0.
REQ-030 Write with error: memory unchanged.
REQ-031 Read: PRDATA = mem[index] while PREADY=1, PWRITE captured 0, no error; PRDATA = 0 otherwise; PSTRB ignored.
REQ-032 Inputs changing during ACCESS SHALL not affect the transfer (captured values used), except PSELx (REQ-023).

Reset
REQ-033 PRESETn=0 SHALL immediately force state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all memory words=0.
REQ-034 Reset asserted mid-ACCESS SHALL abort the transfer with no memory write; first setup after release is accepted normally.

Verification
REQ-035 Write 0xDEADBEEF to 0x08, PSTRB=4'hF, defaults -> PREADY low 2 access cycles, high on 3rd; PSLVERR=0; read 0x08 returns 0xDEADBEEF.
REQ-036 Mem[0x04]=0x11223344; write 0xAABBCCDD, PSTRB=4'b0101 -> read 0x04 returns 0x11BB33DD.
REQ-037 Read 0x40 (index 16) and write 0x06 (misaligned) -> PREADY=1 with PSLVERR=1, PRDATA=0, memory unchanged.
REQ-038 WAIT_CYCLES=0, back-to-back write 0x00 then read 0x00 -> each transfer 2 cycles, PREADY high in first access cycle, readback matches.
REQ-039 PRESETn pulsed low during wait cycle 1 of write 0x0C -> outputs 0 immediately, read 0x0C after release returns 0x00000000.
REQ-040 PSELx dropped after setup of write 0x10 -> no PREADY, PSLVERR=0, read 0x10 returns prior value.

Source files
------------

// File: rtl/apb_slv_mem.sv
// APB slave with a small word-addressed memory, programmable wait states,
// byte-lane write strobes and error signalling for out-of-range or misaligned
// addresses.
module apb_slv_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSELx,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   localparam logic [3:0]            WAIT_L     = 4'(WAIT_CYCLES);

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } state_t;

   state_t                  r_state;
   logic [3:0]              r_waitCnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_write;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [BYTES-1:0]        r_strb;
   logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0]   w_wordIdx;
   logic [IDX_W-1:0]        w_memIdx;
   logic                    w_err;
   logic                    w_ready;

   // Decode the captured address into a word index and flag range/alignment errors
   always_comb begin
      w_wordIdx = r_addr >> LSB;
      w_memIdx  = w_wordIdx[IDX_W-1:0];
      w_err     = ({1'b0, w_wordIdx} >= DEPTH_L) || ((r_addr & ALIGN_MASK) != '0);
   end

   // Bus outputs depend only on state and counter, never directly on bus inputs
   always_comb begin
      w_ready = (r_state == S_ACCESS) && (r_waitCnt == 4'd0);
      PREADY  = w_ready;
      PSLVERR = w_ready && w_err;
      PRDATA  = (w_ready && !r_write && !w_err) ? r_mem[w_memIdx] : '0;
   end

   // Transfer FSM: capture on setup, count wait states, commit writes on completion
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state   <= S_IDLE;
         r_waitCnt <= 4'd0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_strb    <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (PSELx && !PENABLE) begin
                  r_state   <= S_ACCESS;
                  r_waitCnt <= WAIT_L;
                  r_addr    <= PADDR;
                  r_write   <= PWRITE;
                  r_wdata   <= PWDATA;
                  r_strb    <= PSTRB;
               end
            end
            S_ACCESS: begin
               if (!PSELx) begin
                  r_state   <= S_IDLE;
                  r_waitCnt <= 4'd0;
               end else if (r_waitCnt != 4'd0) begin
                  r_waitCnt <= r_waitCnt - 4'd1;
               end else if (PENABLE) begin
                  r_state <= S_IDLE;
                  if (r_write && !w_err) begin
                     for (int b = 0; b < BYTES; b++) begin
                        if (r_strb[b]) begin
                           r_mem[w_memIdx][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
